pwm_speed_ramp: RTL

//   Soft-start/soft-stop controller directly upstream of the PWM generator (ancho).

---
 rtl/pwm_speed_ramp.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pwm_speed_ramp.sv
// Soft-start/soft-stop speed ramp feeding the PWM stage.
// Synchronises run/target, filters target glitches, slews speed by one step per tick.
module pwm_speed_ramp #(
    parameter int SPEED_W       = 3,
    parameter int RAMP_TICKS    = 1000,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               run_req,
    input  logic [SPEED_W-1:0] target_speed,
    output logic               pwm_enable,
    output logic [SPEED_W-1:0] pwm_speed,
    output logic               busy,
    output logic               at_target
);

    localparam int TW = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(RAMP_TICKS - 1);
    localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF,
        S_RAMP,
        S_HOLD,
        S_STOP
    } state_t;

    state_t state;

    logic [SYNC_STAGES-1:0] run_sync;
    logic [SPEED_W-1:0]     tgt_sync [SYNC_STAGES];
    logic                   run_s;
    logic [SPEED_W-1:0]     tgt_s;
    logic [SPEED_W-1:0]     tgt_prev;
    logic [SPEED_W-1:0]     tgt_q;
    logic [SW-1:0]          stab_cnt;
    logic [SW-1:0]          stab_nxt;
    logic [TW-1:0]          tick_cnt;
    logic                   tick;

    assign run_s = run_sync[SYNC_STAGES-1];
    assign tgt_s = tgt_sync[SYNC_STAGES-1];
    assign tick  = (tick_cnt == TICK_LAST);

    // Next stability count: clears on any change, saturates at the accept point.
    always_comb begin
        stab_nxt = '0;
        if (tgt_s != tgt_prev) begin
            stab_nxt = '0;
        end else if (stab_cnt == STAB_LAST) begin
            stab_nxt = stab_cnt;
        end else begin
            stab_nxt = stab_cnt + SW'(1);
        end
    end

    // Pad synchronisers and the target glitch filter.
    always_ff @(posedge clock) begin
        if (reset) begin
            run_sync <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                tgt_sync[i] <= '0;
            end
            tgt_prev <= '0;
            stab_cnt <= '0;
            tgt_q    <= '0;
        end else begin
            run_sync[0] <= run_req;
            tgt_sync[0] <= target_speed;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                run_sync[i] <= run_sync[i-1];
                tgt_sync[i] <= tgt_sync[i-1];
            end
            tgt_prev <= tgt_s;
            stab_cnt <= stab_nxt;
            if (stab_nxt == STAB_LAST) begin
                tgt_q <= tgt_s;
            end
        end
    end

    // Ramp FSM with tick counter and registered PWM-side outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= S_OFF;
            tick_cnt   <= '0;
            pwm_enable <= 1'b0;
            pwm_speed  <= '0;
            busy       <= 1'b0;
            at_target  <= 1'b0;
        end else begin
            unique case (state)
                S_OFF: begin
                    tick_cnt <= '0;
                    if (run_s) begin
                        state      <= S_RAMP;
                        pwm_enable <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                S_RAMP: begin
                    if (!run_s) begin
                        state    <= S_STOP;
                        tick_cnt <= '0;
                    end else if (pwm_speed == tgt_q) begin
                        state     <= S_HOLD;
                        busy      <= 1'b0;
                        at_target <= 1'b1;
                        tick_cnt  <= '0;
                    end else if (tick) begin
                        tick_cnt <= '0;
                        if (tgt_q > pwm_speed) begin
                            pwm_speed <= pwm_speed + SPEED_W'(1);
                        end else begin
                            pwm_speed <= pwm_speed - SPEED_W'(1);
                        end
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
                S_HOLD: begin
                    tick_cnt <= '0;
                    if (!run_s) begin
                        state     <= S_STOP;
                        busy      <= 1'b1;
                        at_target <= 1'b0;
                    end else if (tgt_q != pwm_speed) begin
                        state     <= S_RAMP;
                        busy      <= 1'b1;
                        at_target <= 1'b0;
                    end
                end
                S_STOP: begin
                    if (run_s) begin
                        state    <= S_RAMP;
                        tick_cnt <= '0;
                    end else if (pwm_speed == '0) begin
                        state      <= S_OFF;
                        pwm_enable <= 1'b0;
                        busy       <= 1'b0;
                        tick_cnt   <= '0;
                    end else if (tick) begin
                        tick_cnt  <= '0;
                        pwm_speed <= pwm_speed - SPEED_W'(1);
                    end else begin
                        tick_cnt <= tick_cnt + TW'(1);
                    end
                end
            endcase
        end
    end

endmodule
